priv_control_unit: RTL
======================

Name: priv_control_unit

Overview:
- Parametrised successor of the single-cycle decode/control unit.
- Keeps the combinational opcode decode and adds a registered privilege FSM (MACHINE / USER / TRAP), ECALL/MRET/illegal-opcode trap generation, a multi-cycle flush window, and wrap-around cycle/instret counters.
- Sits in the decode stage.
- Drives the datapath control signals and a trap redirect request to the fetch unit.

Parameters:
- CORE, 0, core index used in report output.
- DATA_WIDTH, 32, width of pc and trap_epc.
- CNT_WIDTH, 32, width of the cycles and instret counters.
- FLUSH_CYCLES, 2, number of cycles spent in TRAP; legal range >= 1.
- USER_OPCODE, 7'b0001011, custom0 opcode that enters USER mode.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- valid  in  1  decode-stage instruction valid.
- stall  in  1  pipeline stall; freezes the FSM and instret.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct12  in  12  instruction[31:20].
- pc  in  DATA_WIDTH  pc of the decode-stage instruction.
- report  in  1  enables $display dump.
- regWrite, memRead, memWrite, memtoReg, branch_op  out  1 each  datapath controls, RV32I encoding.
- ALUOp  out  3  ALU operation class.
- next_PC_sel  out  2  next-pc select.
- operand_A_sel  out  2  ALU operand A select.
- extend_sel  out  2  immediate extend select.
- operand_B_sel, rs1_used, rs2_used  out  1 each.
- userMode  out  1  1 when the FSM is in USER.
- flush  out  1  high in every TRAP-state cycle.
- trap_req  out  1  one-cycle pulse; fetch redirects to the trap vector.
- trap_cause  out  4  cause code: 2 = illegal, 8 = ecall-from-user, 11 = ecall-from-machine.
- trap_epc  out  DATA_WIDTH  pc of the trapping instruction.
- cycles  out  CNT_WIDTH  cycle counter.
- instret  out  CNT_WIDTH  retired-instruction counter.

Behaviour:
- Reset values: FSM=MACHINE, userMode=0, prev_user=0, flush=0, trap_req=0, trap_cause=0, trap_epc=0, cycles=0, instret=0, flush counter=0.
- Reset taken in any state (including mid-TRAP) returns to these values on the next edge.
- "fire" = valid & !stall & FSM!=TRAP.
- ECALL = opcode 1110011, funct3=0, funct12=0x000.
- MRET = opcode 1110011, funct3=0, funct12=0x302.
- Illegal = any of:
  - opcode not one of the 11 RV32I opcodes and not USER_OPCODE;
  - in USER: opcode 1110011 other than ECALL;
  - in USER: USER_OPCODE;
  - in MACHINE: opcode 1110011 with funct3=0 and funct12 not in {0x000, 0x302}.
- trap_det = fire & (ECALL | Illegal). In any fire cycle, ECALL/Illegal takes priority over any mode transition.
- Decode outputs are combinational from opcode, same encodings as the existing control unit.
- regWrite, memRead, memWrite, branch_op, next_PC_sel and memtoReg are forced to 0 when trap_det=1 or FSM=TRAP.
- MACHINE transitions:
  - fire & opcode==USER_OPCODE -> USER next edge.
  - fire & MRET -> USER if prev_user=1, else stay MACHINE.
  - trap_det -> TRAP.
- USER transitions:
  - trap_det -> TRAP, with prev_user<=1.
  - Any other instruction -> stay USER.
- Entry into TRAP (on the trap_det edge):
  - trap_epc<=pc.
  - trap_cause<=2 for Illegal; otherwise 8 if from USER, 11 if from MACHINE.
  - trap_req=1 for exactly the first TRAP cycle.
  - Flush counter loads FLUSH_CYCLES-1.
- In TRAP:
  - flush=1, userMode=0; valid, opcode and stall are ignored.
  - Counter decrements each cycle; at 0 the FSM -> MACHINE next edge.
  - TRAP lasts exactly FLUSH_CYCLES cycles.
- prev_user is cleared on entry to TRAP from MACHINE.
- stall=1 blocks all transitions and instret; cycles and the TRAP countdown still advance.
- Counters:
  - cycles increments every non-reset cycle.
  - instret increments on fire & !trap_det.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- userMode changes one cycle after the causing instruction (registered).

Decomposition:
- Shared package ctrl_pkg holds:
  - RV32I opcode constants and USER_OPCODE default;
  - mode enum {MACHINE, USER, TRAP};
  - cause codes 2/8/11;
  - FUNCT12_ECALL=0x000, FUNCT12_MRET=0x302.
- Sub-module opcode_decoder: pure combinational decode of opcode to the datapath controls plus a known_opcode flag.
- The top-level module holds the FSM, the trap capture registers, the force-to-zero gating and the counters.

Test Plan:
- Reset, then valid=1 with opcode 0110011 -> regWrite=1, userMode=0, instret=1 after one edge, cycles counting from 0.
- Opcode 0001011 in MACHINE -> userMode=1 next cycle; then ECALL at pc=0x100 -> memWrite/regWrite=0 that cycle, trap_req pulse, trap_cause=8, trap_epc=0x100, flush high for exactly 2 cycles, then MACHINE, userMode=0.
- In USER, CSR op (1110011, funct3=1) -> trap_cause=2, instret not incremented; afterwards MRET in MACHINE -> userMode=1.
- Opcode 0001011 or an unknown opcode 1111111 held with stall=1 for 3 cycles -> no mode change, no trap, instret constant; release stall -> transition/trap on the next edge.
- Reset asserted during the second TRAP cycle -> next edge: flush=0, trap_epc=0, trap_cause=0, userMode=0, cycles=0.
- CNT_WIDTH=4: run 17 cycles -> cycles wraps 15->0 and reads 1; FLUSH_CYCLES=1 -> flush is high for a single cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-stage control unit: RV32I opcodes,
// privilege mode encoding, trap cause codes, SYSTEM funct12 values and the
// bundle of datapath control signals produced by the opcode decoder.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // custom0: enters USER mode from MACHINE
    localparam logic [6:0] USER_OPCODE_DEFAULT = 7'b0001011;

    typedef enum logic [1:0] {
        MACHINE = 2'd0,
        USER    = 2'd1,
        TRAP    = 2'd2
    } mode_e;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    localparam logic [11:0] FUNCT12_ECALL = 12'h000;
    localparam logic [11:0] FUNCT12_MRET  = 12'h302;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       branch_op;
        logic [2:0] alu_op;
        logic [1:0] next_pc_sel;
        logic [1:0] operand_a_sel;
        logic [1:0] extend_sel;
        logic       operand_b_sel;
        logic       rs1_used;
        logic       rs2_used;
        logic       known_opcode;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational decode of a 7-bit opcode into datapath controls.
// Ports: opcode (in, 7) -> ctrl (out, ctrl_t). Unknown opcodes decode to all
// zeros with known_opcode = 0.
//   ALUOp: 000 R, 001 I-arith, 010 branch, 011 jump, 100 load, 101 store,
//          110 upper-imm, 111 system
//   next_PC_sel: 00 pc+4, 01 branch, 10 jal, 11 jalr
//   operand_A_sel: 00 rs1, 01 pc, 10 pc (link), 11 zero
//   extend_sel: 00 I, 01 S, 10 B, 11 U
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.known_opcode = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 3'b000;
                ctrl.rs1_used  = 1'b1;
                ctrl.rs2_used  = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_op        = 3'b001;
                ctrl.operand_b_sel = 1'b1;
                ctrl.rs1_used      = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.reg_write     = 1'b1;
                ctrl.mem_read      = 1'b1;
                ctrl.memto_reg     = 1'b1;
                ctrl.alu_op        = 3'b100;
                ctrl.operand_b_sel = 1'b1;
                ctrl.rs1_used      = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write     = 1'b1;
                ctrl.alu_op        = 3'b101;
                ctrl.operand_b_sel = 1'b1;
                ctrl.extend_sel    = 2'b01;
                ctrl.rs1_used      = 1'b1;
                ctrl.rs2_used      = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch_op   = 1'b1;
                ctrl.alu_op      = 3'b010;
                ctrl.next_pc_sel = 2'b01;
                ctrl.extend_sel  = 2'b10;
                ctrl.rs1_used    = 1'b1;
                ctrl.rs2_used    = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_op        = 3'b011;
                ctrl.next_pc_sel   = 2'b10;
                ctrl.operand_a_sel = 2'b10;
            end
            OPC_JALR: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_op        = 3'b011;
                ctrl.next_pc_sel   = 2'b11;
                ctrl.operand_a_sel = 2'b10;
                ctrl.operand_b_sel = 1'b1;
                ctrl.rs1_used      = 1'b1;
            end
            OPC_LUI: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_op        = 3'b110;
                ctrl.operand_a_sel = 2'b11;
                ctrl.operand_b_sel = 1'b1;
                ctrl.extend_sel    = 2'b11;
            end
            OPC_AUIPC: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_op        = 3'b110;
                ctrl.operand_a_sel = 2'b01;
                ctrl.operand_b_sel = 1'b1;
                ctrl.extend_sel    = 2'b11;
            end
            OPC_MISC_MEM: begin
                // fence: legal no-op
            end
            OPC_SYSTEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 3'b111;
                ctrl.rs1_used  = 1'b1;
            end
            default: begin
                ctrl.known_opcode = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/priv_control_unit.sv
// Decode-stage control unit with privilege FSM (MACHINE/USER/TRAP).
// Inputs: clock, reset (sync, active-high), valid, stall, opcode/funct3/
// funct12 fields, pc, report. Outputs: combinational datapath controls
// (gated to zero on a trap), userMode, flush, trap_req pulse, trap_cause,
// trap_epc, and free-running cycles/instret counters.
module priv_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [6:0]  USER_OPCODE  = USER_OPCODE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  stall,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [11:0]           funct12,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  report,
    output logic                  regWrite,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  memtoReg,
    output logic                  branch_op,
    output logic [2:0]            ALUOp,
    output logic [1:0]            next_PC_sel,
    output logic [1:0]            operand_A_sel,
    output logic [1:0]            extend_sel,
    output logic                  operand_B_sel,
    output logic                  rs1_used,
    output logic                  rs2_used,
    output logic                  userMode,
    output logic                  flush,
    output logic                  trap_req,
    output logic [3:0]            trap_cause,
    output logic [DATA_WIDTH-1:0] trap_epc,
    output logic [CNT_WIDTH-1:0]  cycles,
    output logic [CNT_WIDTH-1:0]  instret
);

    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    mode_e                 mode_q, mode_d;
    logic                  prev_user_q, prev_user_d;
    logic                  trap_req_q, trap_req_d;
    logic [3:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;

    ctrl_t dec;
    logic  is_system, f3_zero, is_ecall, is_mret, is_user_op;
    logic  illegal, fire, trap_det, gate;

    // report drives a simulation-only dump that is not part of the hardware
    logic [31:0] unused_core_report;

    opcode_decoder u_opcode_decoder (
        .opcode (opcode),
        .ctrl   (dec)
    );

    always_comb begin
        unused_core_report = 32'(CORE) ^ {31'b0, report};
    end

    always_comb begin
        is_system  = (opcode == OPC_SYSTEM);
        f3_zero    = (funct3 == 3'b000);
        is_ecall   = is_system && f3_zero && (funct12 == FUNCT12_ECALL);
        is_mret    = is_system && f3_zero && (funct12 == FUNCT12_MRET);
        is_user_op = (opcode == USER_OPCODE);
        illegal    = (!dec.known_opcode && !is_user_op)
                  || ((mode_q == USER) && ((is_system && !is_ecall) || is_user_op))
                  || ((mode_q == MACHINE) && is_system && f3_zero && !is_ecall && !is_mret);
        fire       = valid && !stall && (mode_q != TRAP);
        trap_det   = fire && (is_ecall || illegal);
        gate       = trap_det || (mode_q == TRAP);
    end

    always_comb begin
        mode_d      = mode_q;
        prev_user_d = prev_user_q;
        trap_req_d  = 1'b0;
        cause_d     = cause_q;
        epc_d       = epc_q;
        fcnt_d      = fcnt_q;
        cycles_d    = cycles_q + CNT_WIDTH'(1);
        instret_d   = instret_q;

        if (fire && !trap_det) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end

        if (trap_det) begin
            mode_d     = TRAP;
            trap_req_d = 1'b1;
            epc_d      = pc;
            fcnt_d     = FCW'(FLUSH_CYCLES - 1);
            if (illegal) begin
                cause_d = CAUSE_ILLEGAL;
            end else if (mode_q == USER) begin
                cause_d = CAUSE_ECALL_U;
            end else begin
                cause_d = CAUSE_ECALL_M;
            end
            prev_user_d = (mode_q == USER);
        end else begin
            unique case (mode_q)
                MACHINE: begin
                    if (fire && (is_user_op || (is_mret && prev_user_q))) begin
                        mode_d = USER;
                    end
                end
                USER: begin
                    mode_d = USER;
                end
                TRAP: begin
                    if (fcnt_q == '0) begin
                        mode_d = MACHINE;
                    end else begin
                        fcnt_d = fcnt_q - FCW'(1);
                    end
                end
                default: begin
                    mode_d = MACHINE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q      <= MACHINE;
            prev_user_q <= 1'b0;
            trap_req_q  <= 1'b0;
            cause_q     <= '0;
            epc_q       <= '0;
            cycles_q    <= '0;
            instret_q   <= '0;
            fcnt_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            prev_user_q <= prev_user_d;
            trap_req_q  <= trap_req_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            cycles_q    <= cycles_d;
            instret_q   <= instret_d;
            fcnt_q      <= fcnt_d;
        end
    end

    always_comb begin
        regWrite      = dec.reg_write   && !gate;
        memRead       = dec.mem_read    && !gate;
        memWrite      = dec.mem_write   && !gate;
        memtoReg      = dec.memto_reg   && !gate;
        branch_op     = dec.branch_op   && !gate;
        next_PC_sel   = gate ? 2'b00 : dec.next_pc_sel;
        ALUOp         = dec.alu_op;
        operand_A_sel = dec.operand_a_sel;
        extend_sel    = dec.extend_sel;
        operand_B_sel = dec.operand_b_sel;
        rs1_used      = dec.rs1_used;
        rs2_used      = dec.rs2_used;
        userMode      = (mode_q == USER);
        flush         = (mode_q == TRAP);
        trap_req      = trap_req_q;
        trap_cause    = cause_q;
        trap_epc      = epc_q;
        cycles        = cycles_q;
        instret       = instret_q;
    end

endmodule
